// File: rtl/riscv_div_seq.sv
`timescale 1ns/1ps
// riscv_div_seq
//   Sequential RISC-V M-extension divider (DIV/DIVU/REM/REMU) for the EX-stage
//   ALU. Non-restoring radix-2 algorithm retiring BITS_PER_CYC quotient bits
//   per ITER cycle (N = 32/BITS_PER_CYC cycles). Divide-by-zero and signed
//   overflow produce the architectural results directly.
//
//   Build option: RISCV_DIV_EARLY_OUT_EN
//     defined   - divide-by-zero / overflow finish straight from PREP
//     undefined - every operation takes the full N+2 cycle latency
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start_i        request pulse; latches opcode_i, dividend_i, divisor_i
//     opcode_i       0 DIVU, 1 DIV, 2 REMU, 3 REM (bit0 signed, bit1 remainder)
//     dividend_i     rs1
//     divisor_i      rs2
//     busy_o         operation in progress (PREP or ITER)
//     complete_o     result valid; held until the next start_i
//     divide_by_0_o  divisor was zero; valid while complete_o
//     result_o       quotient or remainder; stable while complete_o

module riscv_div_seq #(
    parameter int unsigned BITS_PER_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  opcode_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        complete_o,
    output logic        divide_by_0_o,
    output logic [31:0] result_o
);

    localparam int unsigned N        = 32 / BITS_PER_CYC;
    localparam logic [4:0]  CNT_INIT = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;      // operands as latched
    logic [31:0] aq_q;          // dividend bits shifting out, quotient bits shifting in
    logic [31:0] bm_q;          // divisor magnitude
    logic [32:0] rem_q;         // signed partial remainder
    logic [4:0]  cnt_q;
    logic        q_neg_q, r_neg_q;

    logic        is_signed, a_neg, b_neg, div0, ovf;
    logic [31:0] a_mag, b_mag, spec_res;
    logic [32:0] r_it;
    logic [31:0] q_it, rem_mag, q_fin, r_fin, norm_res;

    // Operand preparation and special cases, from the latched operands
    always_comb begin
        is_signed = op_q[0];
        a_neg     = is_signed & a_q[31];
        b_neg     = is_signed & b_q[31];
        a_mag     = a_neg ? (32'd0 - a_q) : a_q;
        b_mag     = b_neg ? (32'd0 - b_q) : b_q;
        div0      = (b_q == '0);
        ovf       = is_signed && (a_q == 32'h8000_0000) && (b_q == '1);
        if (div0)
            spec_res = op_q[1] ? a_q : '1;
        else
            spec_res = op_q[1] ? '0 : 32'h8000_0000;
    end

    // BITS_PER_CYC non-restoring steps; the quotient bit is set whenever the
    // new partial remainder is non-negative.
    always_comb begin
        r_it = rem_q;
        q_it = aq_q;
        for (int unsigned i = 0; i < BITS_PER_CYC; i++) begin
            if (r_it[32])
                r_it = {r_it[31:0], q_it[31]} + {1'b0, bm_q};
            else
                r_it = {r_it[31:0], q_it[31]} - {1'b0, bm_q};
            q_it = {q_it[30:0], ~r_it[32]};
        end
        // Restored remainder lies in [0, divisor) so the low 32 bits suffice
        rem_mag  = r_it[31:0] + (r_it[32] ? bm_q : '0);
        q_fin    = q_neg_q ? (32'd0 - q_it) : q_it;
        r_fin    = r_neg_q ? (32'd0 - rem_mag) : rem_mag;
        norm_res = op_q[1] ? r_fin : q_fin;
    end

    // State register and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            aq_q          <= '0;
            bm_q          <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            divide_by_0_o <= 1'b0;
            result_o      <= '0;
        end else begin
            state_q <= state_d;
            if (start_i) begin
                op_q <= opcode_i;
                a_q  <= dividend_i;
                b_q  <= divisor_i;
            end else begin
                case (state_q)
                    PREP: begin
                        aq_q    <= a_mag;
                        bm_q    <= b_mag;
                        rem_q   <= '0;
                        cnt_q   <= CNT_INIT;
                        q_neg_q <= is_signed & (a_q[31] ^ b_q[31]);
                        r_neg_q <= a_neg;
                    end
                    ITER: begin
                        aq_q  <= q_it;
                        rem_q <= r_it;
                        cnt_q <= cnt_q - 5'd1;
                    end
                    default: ;
                endcase
            end
            // Result is registered on the edge that enters DONE
            if (state_d == DONE && state_q != DONE) begin
                result_o      <= (div0 || ovf) ? spec_res : norm_res;
                divide_by_0_o <= div0;
            end
        end
    end

    // Next-state logic; start_i from any state (re)starts at PREP
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = PREP;
        end else begin
            case (state_q)
                PREP: begin
`ifdef RISCV_DIV_EARLY_OUT_EN
                    state_d = (div0 || ovf) ? DONE : ITER;
`else
                    state_d = ITER;
`endif
                end
                ITER:    if (cnt_q == '0) state_d = DONE;
                default: ;
            endcase
        end
    end

    // Status outputs
    always_comb begin
        busy_o     = 1'b0;
        complete_o = 1'b0;
        case (state_q)
            PREP, ITER: busy_o     = 1'b1;
            DONE:       complete_o = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: doc/riscv_div_seq.md
Name: riscv_div_seq

Overview:
In-house sequential divider that replaces the vendor divide IP inside the EX-stage ALU. It responds to the ALU's start/complete divide handshake. It implements RISC-V M-extension DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed-overflow results, so the ALU result mux needs no special-case fixups. Algorithm: non-restoring, radix-2, BITS_PER_CYC quotient bits per clock.

Parameters:
BITS_PER_CYC, 4, quotient bits retired per ITER cycle; legal values 1, 2, 4, 8; N = 32/BITS_PER_CYC iteration cycles.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle request pulse; samples opcode and operands
opcode_i  input  2  0 DIVU, 1 DIV, 2 REMU, 3 REM; bit0 = signed, bit1 = remainder
dividend_i  input  32  operand a (rs1)
divisor_i  input  32  operand b (rs2)
busy_o  output  1  high in PREP or ITER
complete_o  output  1  result valid; held high until the next start_i
divide_by_0_o  output  1  divisor was zero; valid while complete_o
result_o  output  32  quotient or remainder selected by opcode; held stable while complete_o

Behaviour:
- Reset values: busy_o=0, complete_o=0, divide_by_0_o=0, result_o=0, state=IDLE, all internal registers 0.
- Reset is asynchronous and takes effect mid-operation; no partial result is ever flagged complete.
- States: IDLE, PREP, ITER, DONE.
- IDLE/DONE + start_i -> PREP. Operands and opcode are latched. complete_o drops in the next cycle.
- PREP (1 cycle) when signed: convert operands to magnitudes, record quotient sign = a[31]^b[31] and remainder sign = a[31]. Load the down-counter with N-1.
  - Divisor==0 -> DONE, divide_by_0_o=1. Quotient = 0xFFFFFFFF; remainder = dividend, unmodified.
  - Signed with a=0x80000000, b=0xFFFFFFFF -> DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise -> ITER.
- ITER (N cycles): each cycle retires BITS_PER_CYC quotient bits, MSB first. The partial remainder is 33 bits wide.
- Leaving ITER after the last cycle, in the same edge:
  - restore a negative remainder;
  - apply signs (negate quotient if its sign is set, negate remainder if its sign is set);
  - register result_o; go to DONE.
- DONE: complete_o=1. result_o and divide_by_0_o hold until the next start_i.
- Latency, with start_i high in cycle 0:
  - normal case: complete_o=1 in cycle N+2 (10 at default);
  - special cases: complete_o=1 in cycle 2 (see Optional Feature).
- start_i in PREP or ITER aborts the current operation. The new operands are latched, the sequence restarts at PREP, and no complete_o is produced for the aborted operation.
- start_i in DONE: complete_o falls next cycle and the new operation begins.
- busy_o and complete_o are never high simultaneously.
- Sign rules: remainder takes the dividend's sign. Zero results are never negated to nonzero. |q| < 2^31 is guaranteed apart from the overflow case.

Optional Feature:
Macro RISCV_DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow exit PREP straight to DONE; complete_o in cycle 2.
- Undefined: special cases pass through all N ITER cycles with the iteration result discarded, and the special-case values are loaded at exit. Latency is then a constant N+2 for every operation.
- Result values are identical in both builds.

Test Plan:
1. DIVU 100/7, start at cycle 0 -> result_o=14, complete_o rises in cycle 10, busy_o high cycles 1-9. REMU 100/7 -> 2.
2. DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIV 7/0xFFFFFFFE -> 0xFFFFFFFD. REM 7/-2 -> 1.
3. DIVU 5/0 -> 0xFFFFFFFF, divide_by_0_o=1. REM 0xFFFFFFFB/0 -> 0xFFFFFFFB. Complete in cycle 2 with EARLY_OUT_EN defined, cycle 10 without.
4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. divide_by_0_o=0.
5. Abort: start DIVU 0xFFFFFFFF/3 at cycle 0, start DIVU 9/3 at cycle 4 -> complete_o stays 0 until cycle 14, then result_o=3. No result 0x55555555 ever presented.
6. Reset: assert rst_n=0 in cycle 5 of an ITER -> all outputs 0 immediately. After release with no start_i, complete_o stays 0. Random sweep of 10k operand/opcode pairs matches the golden model for BITS_PER_CYC=1,2,4,8.
